game_timer: RTL
===============

GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, 60, Tick strobes per game second (2..255).
REQ-002 Parameter START_SEC, 60, seconds loaded on Start (1..99).
REQ-003 Parameter WARN_SEC, 10, Warning asserts while remaining seconds <= this value (0..START_SEC).
REQ-004 Clock  input  1  system clock (50 MHz); every flop is posedge Clock.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Tick  input  1  frame enable strobe from the 60 Hz divider, one Clock cycle wide.
REQ-007 Start  input  1  level-sampled command: load START_SEC and run.
REQ-008 Pause  input  1  level-sampled command: toggle between running and paused.
REQ-009 Sec_tens  output  4  BCD tens digit of remaining seconds.
REQ-010 Sec_ones  output  4  BCD ones digit of remaining seconds.
REQ-011 Running  output  1  high while in state RUN.
REQ-012 Sec_pulse  output  1  one-cycle pulse on each second decrement.
REQ-013 Warning  output  1  high in RUN or PAUSED while remaining <= WARN_SEC.
REQ-014 Expired  output  1  one-cycle pulse when count reaches 00.

Function
REQ-015 Four-state FSM with states IDLE, RUN, PAUSED and DONE; all outputs registered.
REQ-016 In IDLE, Start -> RUN, with digits loaded to START_SEC and tick count cleared.
REQ-017 In RUN, Pause -> PAUSED; in PAUSED, Pause -> RUN; Pause is edge-detected internally, so one toggle occurs per rising edge.
REQ-018 In RUN, PAUSED or DONE, Start reloads START_SEC, clears the tick count and enters RUN (restart).
REQ-019 Start and Pause asserted in the same cycle: Start wins and Pause is ignored.
REQ-020 Tick is counted only in RUN; Tick in IDLE, PAUSED or DONE is ignored and the tick count is held.
REQ-021 Tick count wraps 0..TICKS_PER_SEC-1; a Tick at TICKS_PER_SEC-1 clears the count and decrements seconds.
REQ-022 Decrement is BCD: ones 0 becomes 9 with tens-1; otherwise ones-1.
REQ-023 Digits and Sec_pulse update on the cycle after the qualifying Tick (latency 1).
REQ-024 A decrement from 01 to 00 sets the digits to 00, enters DONE and pulses Expired and Sec_pulse in the same cycle.
REQ-025 DONE holds 00 until Start or Reset; no wrap below 00 is permitted.
REQ-026 A Tick coincident with Start is consumed by the reload and does not decrement.
REQ-027 A Tick coincident with Pause in RUN is counted, and the state becomes PAUSED.
REQ-028 Warning is combinationally derived only from registered state and digits, with no input-to-output path.

Reset
REQ-029 Reset is synchronous and active-high, and has priority over all inputs.
REQ-030 Reset values: state IDLE, Sec_tens/Sec_ones = START_SEC in BCD, tick count 0, pause edge register 0, Running 0, Sec_pulse 0, Warning 0, Expired 0.
REQ-031 Reset mid-RUN aborts the countdown with no Expired or Sec_pulse generated.

Structure
REQ-032 A shared package holds the FSM state encoding (2 bits) and the BCD digit width constant.
REQ-033 One sub-module, bcd_down_counter, implements 2-digit BCD load/decrement/zero-detect; the FSM and tick prescaler stay in game_timer.
REQ-034 Tick counter width is $clog2(TICKS_PER_SEC); no other counter is wider than 8 bits.

Verification (TICKS_PER_SEC=2, START_SEC=3, WARN_SEC=2 unless stated)
REQ-035 Reset, then Start, then 6 Ticks -> digits 03->02->01->00 after Ticks 2/4/6; Sec_pulse on those cycles; Expired once, coincident with 00; Running drops; Warning high at 02 and 01 and low in DONE.
REQ-036 Start, 2 Ticks (count 02), Pause, 4 Ticks, Pause again, 2 Ticks -> digits 02 throughout the paused Ticks, then 01; Running 0 while paused.
REQ-037 Start and Pause in the same cycle from IDLE -> RUN with digits 03; Start coincident with a Tick -> no decrement.
REQ-038 In DONE, apply 5 Ticks then Start -> digits hold 00 with no pulses, then reload to 03 and enter RUN.
REQ-039 Reset asserted after the 3rd Tick -> next cycle: IDLE, digits 03, all outputs 0, no Expired.
REQ-040 With defaults (60/60/10), run 60*60 Ticks -> BCD borrow 10->09 observed, Warning first high at 10, Expired exactly at Tick 3600.

Source files
------------

// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared FSM state encoding, BCD digit width and BCD helper for the game timer
package game_timer_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;
  localparam int DIGIT_W = 4;
  function automatic logic [2*DIGIT_W-1:0] to_bcd(input int v);
    return {DIGIT_W'(v / 10), DIGIT_W'(v % 10)};
  endfunction
endpackage

// File: rtl/game_timer_bcd_down_counter.sv
// bcd_down_counter: two-digit BCD register with load, decrement (saturating at 00) and 01 detect
//   clk, rst     : clock, synchronous active-high reset (loads INIT)
//   load         : reload INIT; wins over dec
//   dec          : decrement one second in BCD
//   tens, ones   : BCD digits
//   is_one       : digits currently read 01 (the next decrement reaches 00)
module bcd_down_counter
  import game_timer_pkg::*;
#(
  parameter logic [2*DIGIT_W-1:0] INIT = 8'h60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               is_one
);
  logic is_zero;
  assign is_zero = (tens == '0) && (ones == '0);
  assign is_one  = (tens == '0) && (ones == DIGIT_W'(1));
  always_ff @(posedge clk)
    if (rst || load) {tens, ones} <= INIT;
    else if (dec && !is_zero) begin
      ones <= (ones == '0) ? DIGIT_W'(9) : ones - DIGIT_W'(1);
      tens <= (ones == '0) ? tens - DIGIT_W'(1) : tens;
    end
endmodule

// File: rtl/game_timer.sv
// game_timer: BCD countdown game timer with tick prescaler, start/pause FSM and warning/expiry flags
//   Clock, Reset       : clock, synchronous active-high reset
//   Tick               : one-cycle frame strobe, counted only while running
//   Start              : load START_SEC and run (wins over Pause)
//   Pause              : rising edge toggles running/paused
//   Sec_tens, Sec_ones : BCD digits of remaining seconds
//   Running            : registered, high in RUN
//   Sec_pulse          : one-cycle pulse per second decrement
//   Warning            : high in RUN/PAUSED while remaining <= WARN_SEC
//   Expired            : one-cycle pulse when the count reaches 00
module game_timer
  import game_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 60,
  parameter int START_SEC     = 60,
  parameter int WARN_SEC      = 10
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Tick,
  input  logic               Start,
  input  logic               Pause,
  output logic [DIGIT_W-1:0] Sec_tens,
  output logic [DIGIT_W-1:0] Sec_ones,
  output logic               Running,
  output logic               Sec_pulse,
  output logic               Warning,
  output logic               Expired
);
  localparam int TW = $clog2(TICKS_PER_SEC);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
  localparam logic [7:0] WARN = 8'(WARN_SEC);
  state_t state, state_nx;
  logic [TW-1:0] tick_cnt, tick_cnt_nx;
  logic pause_q, pause_rise, load, dec, expire, is_one;
  logic [7:0] remaining;
  assign pause_rise = Pause && !pause_q;
  // Binary value of the registered digits, so Warning has no input-to-output path.
  assign remaining = {4'd0, Sec_tens} * 8'd10 + {4'd0, Sec_ones};
  assign Warning = ((state == RUN) || (state == PAUSED)) && (remaining <= WARN);
  always_comb begin
    state_nx    = state;
    tick_cnt_nx = tick_cnt;
    load        = 1'b0;
    dec         = 1'b0;
    expire      = 1'b0;
    if (Start) begin
      state_nx    = RUN;
      tick_cnt_nx = '0;
      load        = 1'b1;
    end else if (state == RUN) begin
      if (Tick) begin
        tick_cnt_nx = (tick_cnt == TICK_MAX) ? '0 : tick_cnt + TW'(1);
        dec         = (tick_cnt == TICK_MAX);
        expire      = dec && is_one;
      end
      // Reaching 00 takes priority over a coincident pause request.
      state_nx = expire ? DONE : pause_rise ? PAUSED : RUN;
    end else if (state == PAUSED && pause_rise) begin
      state_nx = RUN;
    end
  end
  always_ff @(posedge Clock)
    if (Reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      pause_q   <= 1'b0;
      Running   <= 1'b0;
      Sec_pulse <= 1'b0;
      Expired   <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_cnt  <= tick_cnt_nx;
      pause_q   <= Pause;
      Running   <= (state_nx == RUN);
      Sec_pulse <= dec;
      Expired   <= expire;
    end
  bcd_down_counter #(.INIT(to_bcd(START_SEC))) u_cnt (
    .clk   (Clock),
    .rst   (Reset),
    .load  (load),
    .dec   (dec),
    .tens  (Sec_tens),
    .ones  (Sec_ones),
    .is_one(is_one)
  );
endmodule
